// File: rtl/hazard_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard/forwarding controller.
// Covers the operand-select codes, FSM states and the bundled stage-control word.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    HZ_RUN = 2'd0,
    HZ_LU  = 2'd1,
    HZ_MW  = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic bubble_f;
    logic bubble_d;
    logic flush_d;
    logic bubble_e;
    logic flush_e;
    logic bubble_m;
    logic bubble_w;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_IDLE    = '0;
  localparam hz_ctrl_t CTRL_FREEZE  = '{bubble_f: 1'b1, bubble_d: 1'b1, flush_d: 1'b0,
                                        bubble_e: 1'b1, flush_e: 1'b0, bubble_m: 1'b1,
                                        bubble_w: 1'b1};
  localparam hz_ctrl_t CTRL_BRANCH  = '{bubble_f: 1'b0, bubble_d: 1'b0, flush_d: 1'b1,
                                        bubble_e: 1'b0, flush_e: 1'b1, bubble_m: 1'b0,
                                        bubble_w: 1'b0};
  localparam hz_ctrl_t CTRL_LOADUSE = '{bubble_f: 1'b1, bubble_d: 1'b1, flush_d: 1'b0,
                                        bubble_e: 1'b0, flush_e: 1'b1, bubble_m: 1'b0,
                                        bubble_w: 1'b0};

  // A load into x0 never creates a dependency.
  function automatic logic load_use(input logic is_load, input reg_idx_t rd,
                                    input reg_idx_t src1, input reg_idx_t src2);
    return is_load && (rd != '0) && ((rd == src1) || (rd == src2));
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding select for one EXE source operand.
// MEM result has priority over WB; x0 always reads the register file.
module fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src_i,
  input  logic [REG_W-1:0] rd_mem_i,
  input  logic             wen_mem_i,
  input  logic [REG_W-1:0] rd_wb_i,
  input  logic             wen_wb_i,
  output logic [1:0]       sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (src_i != '0) begin
      if (wen_mem_i && (rd_mem_i == src_i)) begin
        sel_o = FWD_MEM;
      end else if (wen_wb_i && (rd_wb_i == src_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and forwarding controller: load-use stalls, branch flushes,
// memory-busy freeze, MEM/WB destination shadows and saturating event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       reg_src1_id,
  input  logic [4:0]       reg_src2_id,
  input  logic [4:0]       reg_src1_exe,
  input  logic [4:0]       reg_src2_exe,
  input  logic [4:0]       rd_exe,
  input  logic             reg_w_en_exe,
  input  logic             dm_r_en_exe,
  input  logic             br_taken_exe,
  input  logic             mem_busy,
  output logic [1:0]       rs_value_from,
  output logic [1:0]       rt_value_from,
  output logic             bubbleF,
  output logic             bubbleD,
  output logic             flushD,
  output logic             bubbleE,
  output logic             flushE,
  output logic             bubbleM,
  output logic             bubbleW,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_e         state_q, state_d;
  reg_idx_t          rd_mem_q, rd_wb_q;
  logic              wen_mem_q, wen_wb_q;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  hz_ctrl_t          ctrl;
  logic              lu;

  assign lu = load_use(dm_r_en_exe, rd_exe, reg_src1_id, reg_src2_id);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= HZ_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = HZ_RUN;
    if (mem_busy) begin
      state_d = HZ_MW;
    end else if (br_taken_exe) begin
      state_d = HZ_RUN;
    end else if (lu && (state_q == HZ_RUN)) begin
      state_d = HZ_LU;
    end
  end

  // Output logic; gated by rstn so a held reset also clears the combinational controls.
  always_comb begin
    ctrl = CTRL_IDLE;
    if (!rstn) begin
      ctrl = CTRL_IDLE;
    end else if (mem_busy) begin
      ctrl = CTRL_FREEZE;
    end else if (br_taken_exe) begin
      ctrl = CTRL_BRANCH;
    end else if (lu && (state_q == HZ_RUN)) begin
      ctrl = CTRL_LOADUSE;
    end
  end

  assign bubbleF = ctrl.bubble_f;
  assign bubbleD = ctrl.bubble_d;
  assign flushD  = ctrl.flush_d;
  assign bubbleE = ctrl.bubble_e;
  assign flushE  = ctrl.flush_e;
  assign bubbleM = ctrl.bubble_m;
  assign bubbleW = ctrl.bubble_w;

  // Shadows freeze on the same edges the frozen pipe registers hold, i.e. whenever
  // the next state is MW, keeping them aligned with the MEM/WB contents.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_mem_q  <= '0;
      wen_mem_q <= 1'b0;
      rd_wb_q   <= '0;
      wen_wb_q  <= 1'b0;
    end else if (state_d != HZ_MW) begin
      rd_mem_q  <= rd_exe;
      wen_mem_q <= reg_w_en_exe;
      rd_wb_q   <= rd_mem_q;
      wen_wb_q  <= wen_mem_q;
    end
  end

  fwd_sel u_fwd_rs (
    .src_i     (reg_src1_exe),
    .rd_mem_i  (rd_mem_q),
    .wen_mem_i (wen_mem_q),
    .rd_wb_i   (rd_wb_q),
    .wen_wb_i  (wen_wb_q),
    .sel_o     (rs_value_from)
  );

  fwd_sel u_fwd_rt (
    .src_i     (reg_src2_exe),
    .rd_mem_i  (rd_mem_q),
    .wen_mem_i (wen_mem_q),
    .rd_wb_i   (rd_wb_q),
    .wen_wb_i  (wen_wb_q),
    .sel_o     (rt_value_from)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (ctrl.bubble_f && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (ctrl.flush_d && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch, memory freeze,
// x0 handling, counter saturation and asynchronous reset.
module tb_hazard_ctrl;

  localparam int unsigned CW = 4;
  localparam int CMAX = 15;

  localparam logic [31:0] C_IDLE = 32'b0000000;
  localparam logic [31:0] C_LU   = 32'b1100100;
  localparam logic [31:0] C_BR   = 32'b0010100;
  localparam logic [31:0] C_BUSY = 32'b1101011;

  logic          clk = 1'b0;
  logic          rstn;
  logic [4:0]    reg_src1_id, reg_src2_id, reg_src1_exe, reg_src2_exe, rd_exe;
  logic          reg_w_en_exe, dm_r_en_exe, br_taken_exe, mem_busy;
  logic [1:0]    rs_value_from, rt_value_from;
  logic          bubbleF, bubbleD, flushD, bubbleE, flushE, bubbleM, bubbleW;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_chk = 0;
  int n_bad = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .reg_src1_id   (reg_src1_id),
    .reg_src2_id   (reg_src2_id),
    .reg_src1_exe  (reg_src1_exe),
    .reg_src2_exe  (reg_src2_exe),
    .rd_exe        (rd_exe),
    .reg_w_en_exe  (reg_w_en_exe),
    .dm_r_en_exe   (dm_r_en_exe),
    .br_taken_exe  (br_taken_exe),
    .mem_busy      (mem_busy),
    .rs_value_from (rs_value_from),
    .rt_value_from (rt_value_from),
    .bubbleF       (bubbleF),
    .bubbleD       (bubbleD),
    .flushD        (flushD),
    .bubbleE       (bubbleE),
    .flushE        (flushE),
    .bubbleM       (bubbleM),
    .bubbleW       (bubbleW),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ctl();
    return 32'({bubbleF, bubbleD, flushD, bubbleE, flushE, bubbleM, bubbleW});
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic idle();
    reg_src1_id  = '0;
    reg_src2_id  = '0;
    reg_src1_exe = '0;
    reg_src2_exe = '0;
    rd_exe       = '0;
    reg_w_en_exe = 1'b0;
    dm_r_en_exe  = 1'b0;
    br_taken_exe = 1'b0;
    mem_busy     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    tick();
    tick();
    mem_busy = 1'b1;
    #1;
    chk("rst_ctl", ctl(), C_IDLE);
    chk("rst_rs", 32'(rs_value_from), 0);
    chk("rst_rt", 32'(rt_value_from), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_flush", 32'(flush_cnt), 0);
    mem_busy = 1'b0;
    rstn = 1'b1;

    // add x5 in EXE, then consumers one and two cycles later
    tick();
    idle(); rd_exe = 5; reg_w_en_exe = 1'b1; #1;
    chk("fw_none", 32'(rs_value_from), 0);
    tick();
    idle(); rd_exe = 9; reg_w_en_exe = 1'b1; reg_src1_exe = 5; #1;
    chk("fw_mem_rs", 32'(rs_value_from), 1);
    chk("fw_mem_rt0", 32'(rt_value_from), 0);
    tick();
    idle(); rd_exe = 9; reg_w_en_exe = 1'b1; reg_src1_exe = 9; reg_src2_exe = 5; #1;
    chk("fw_mem_rs9", 32'(rs_value_from), 1);
    chk("fw_wb_rt5", 32'(rt_value_from), 2);
    tick();
    idle(); reg_src1_exe = 9; reg_src2_exe = 5; #1;
    chk("fw_mem_wins", 32'(rs_value_from), 1);
    chk("fw_aged_out", 32'(rt_value_from), 0);
    tick();
    idle(); reg_src1_exe = 9; #1;
    chk("fw_wb_only", 32'(rs_value_from), 2);
    tick();
    idle();
    tick();

    // lw x6 ; add x7,x6,x6
    idle(); rd_exe = 6; reg_w_en_exe = 1'b1; dm_r_en_exe = 1'b1;
    reg_src1_id = 6; reg_src2_id = 6; #1;
    chk("lu_ctl", ctl(), C_LU);
    exp_stall = sat(exp_stall);
    tick();
    idle(); #1;
    chk("lu_next_idle", ctl(), C_IDLE);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    tick();
    idle(); reg_src1_exe = 6; reg_src2_exe = 6; rd_exe = 7; reg_w_en_exe = 1'b1; #1;
    chk("lu_dep_rs", 32'(rs_value_from), 2);
    chk("lu_dep_rt", 32'(rt_value_from), 2);
    chk("lu_dep_stall", 32'(stall_cnt), 1);

    // a persisting lu is ignored in LU, then stalls again from RUN
    tick();
    idle(); rd_exe = 3; reg_w_en_exe = 1'b1; dm_r_en_exe = 1'b1; reg_src2_id = 3; #1;
    chk("lu2_ctl", ctl(), C_LU);
    exp_stall = sat(exp_stall);
    tick(); #1;
    chk("lu2_in_lu", ctl(), C_IDLE);
    tick(); #1;
    chk("lu2_again", ctl(), C_LU);
    exp_stall = sat(exp_stall);
    tick();
    idle(); #1;
    chk("lu2_stall_cnt", 32'(stall_cnt), 32'(exp_stall));

    // taken branch with simultaneous load-use
    tick();
    idle(); br_taken_exe = 1'b1; rd_exe = 6; reg_w_en_exe = 1'b1; dm_r_en_exe = 1'b1;
    reg_src1_id = 6; #1;
    chk("br_ctl", ctl(), C_BR);
    exp_flush = sat(exp_flush);
    tick();
    idle(); rd_exe = 4; reg_w_en_exe = 1'b1; dm_r_en_exe = 1'b1; reg_src1_id = 4; #1;
    chk("br_flush_cnt", 32'(flush_cnt), 32'(exp_flush));
    chk("br_state_run", ctl(), C_LU);
    exp_stall = sat(exp_stall);
    tick();
    idle();
    tick();

    // memory freeze while x5 sits in MEM
    idle(); rd_exe = 5; reg_w_en_exe = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(); mem_busy = 1'b1; rd_exe = 9; reg_w_en_exe = 1'b1; reg_src1_exe = 5; #1;
      chk("mw_ctl", ctl(), C_BUSY);
      chk("mw_rs", 32'(rs_value_from), 1);
      exp_stall = sat(exp_stall);
      tick();
    end
    idle(); rd_exe = 9; reg_w_en_exe = 1'b1; reg_src1_exe = 5; #1;
    chk("mw_release", ctl(), C_IDLE);
    chk("mw_rs_held", 32'(rs_value_from), 1);
    chk("mw_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    tick();
    idle();
    tick();

    // x0 destination
    idle(); rd_exe = 0; reg_w_en_exe = 1'b1;
    tick();
    idle(); reg_src1_exe = 0; dm_r_en_exe = 1'b1; rd_exe = 0; #1;
    chk("x0_no_fwd", 32'(rs_value_from), 0);
    chk("x0_no_stall", ctl(), C_IDLE);
    tick();

    // saturation of both counters
    for (int i = 0; i < 20; i++) begin
      idle(); mem_busy = 1'b1;
      exp_stall = sat(exp_stall);
      tick();
    end
    idle(); #1;
    chk("sat_stall", 32'(stall_cnt), 32'(exp_stall));
    for (int i = 0; i < 17; i++) begin
      idle(); br_taken_exe = 1'b1;
      exp_flush = sat(exp_flush);
      tick();
    end
    idle(); #1;
    chk("sat_flush", 32'(flush_cnt), 32'(exp_flush));
    chk("sat_flush_max", 32'(flush_cnt), CMAX);

    // asynchronous reset while frozen
    idle(); mem_busy = 1'b1;
    tick(); #1;
    chk("rmw_busy", ctl(), C_BUSY);
    rstn = 1'b0; #1;
    chk("rmw_ctl", ctl(), C_IDLE);
    chk("rmw_stall", 32'(stall_cnt), 0);
    chk("rmw_flush", 32'(flush_cnt), 0);
    tick();
    idle(); rstn = 1'b1;
    rd_exe = 2; reg_w_en_exe = 1'b1; dm_r_en_exe = 1'b1; reg_src1_id = 2; #1;
    chk("rmw_run", ctl(), C_LU);
    tick();
    idle(); #1;
    chk("rmw_stall1", 32'(stall_cnt), 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
